// File: rtl/game_state_sequencer_if.sv
// Bus between the Space Invaders game-flow sequencer and the rest of the VGA
// design: per-frame collision events in, game status and mover controls out.
interface game_state_sequencer_if #(
    parameter int SCORE_W = 14
);
    logic               startOfFrame;
    logic               startKey;
    logic               alienHitPulse;
    logic               playerHitByAlienPulse;
    logic               playerHitByRocketPulse;
    logic               rocketsCollisionPulse;
    logic               aliensReachedBorder;
    logic               game_active;
    logic               freeze;
    logic               rockets_clear;
    logic               level_up;
    logic [2:0]         lives;
    logic [SCORE_W-1:0] score;
    logic [2:0]         level;
    logic [5:0]         aliens_left;
    logic               game_over;
    logic [2:0]         state;

    modport master (
        output startOfFrame, startKey, alienHitPulse, playerHitByAlienPulse,
               playerHitByRocketPulse, rocketsCollisionPulse, aliensReachedBorder,
        input  game_active, freeze, rockets_clear, level_up, lives, score,
               level, aliens_left, game_over, state
    );

    modport slave (
        input  startOfFrame, startKey, alienHitPulse, playerHitByAlienPulse,
               playerHitByRocketPulse, rocketsCollisionPulse, aliensReachedBorder,
        output game_active, freeze, rockets_clear, level_up, lives, score,
               level, aliens_left, game_over, state
    );
endinterface

// File: rtl/game_state_sequencer.sv
// Top-level game flow for Space Invaders: integrates collision pulses once per
// frame and sequences IDLE / PLAY / PLAYER_HIT / LEVEL_CLEAR / GAME_OVER.
// Optional feature macro: GAME_BONUS_LIFE_EN (extra life per 1000 points).
module game_state_sequencer #(
    parameter int START_LIVES       = 3,
    parameter int NUM_ALIENS        = 24,
    parameter int ALIEN_POINTS      = 10,
    parameter int HIT_FREEZE_FRAMES = 60,
    parameter int CLEAR_FRAMES      = 90,
    parameter int MAX_LEVEL         = 7,
    parameter int SCORE_W           = 14
) (
    input logic                   clk,
    input logic                   reset,
    game_state_sequencer_if.slave gs
);
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PLAY        = 3'd1,
        PLAYER_HIT  = 3'd2,
        LEVEL_CLEAR = 3'd3,
        GAME_OVER   = 3'd4
    } state_t;

    localparam int CNT_MAX = (HIT_FREEZE_FRAMES > CLEAR_FRAMES) ? HIT_FREEZE_FRAMES : CLEAR_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 2);
    localparam int EXT_W   = SCORE_W + 16;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t             state_q, state_d;
    logic [2:0]         lives_q, lives_d, lives_b;
    logic [SCORE_W-1:0] score_q, score_d, score_new;
    logic [2:0]         level_q, level_d;
    logic [5:0]         aliens_q, aliens_d, aliens_new;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [EXT_W-1:0]   score_sum;
    logic               key_q, start_edge, expire;
    logic               f_alien, f_dead, f_shot, f_rocket;
    logic               rc_q, rc_d, lu_q, lu_d;
    logic               active_q, active_d, freeze_q, freeze_d, over_q, over_d;
`ifdef GAME_BONUS_LIFE_EN
    logic               bonus;
`endif

    // Key is held as "previous = high" through reset so a key already down
    // when reset releases is not mistaken for a fresh press.
    assign start_edge = gs.startKey & ~key_q;
    assign expire     = (cnt_q <= CNT_W'(1));

    // State register plus all game counters, frame flags and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lives_q  <= '0;
            score_q  <= '0;
            level_q  <= 3'd1;
            aliens_q <= '0;
            cnt_q    <= '0;
            key_q    <= 1'b1;
            f_alien  <= 1'b0;
            f_dead   <= 1'b0;
            f_shot   <= 1'b0;
            f_rocket <= 1'b0;
            rc_q     <= 1'b0;
            lu_q     <= 1'b0;
            active_q <= 1'b0;
            freeze_q <= 1'b1;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lives_q  <= lives_d;
            score_q  <= score_d;
            level_q  <= level_d;
            aliens_q <= aliens_d;
            cnt_q    <= cnt_d;
            key_q    <= gs.startKey;
            rc_q     <= rc_d;
            lu_q     <= lu_d;
            active_q <= active_d;
            freeze_q <= freeze_d;
            over_q   <= over_d;
            // Frame flags: a pulse on the evaluating cycle opens the new frame
            if (state_q != PLAY) begin
                f_alien  <= 1'b0;
                f_dead   <= 1'b0;
                f_shot   <= 1'b0;
                f_rocket <= 1'b0;
            end else if (gs.startOfFrame) begin
                f_alien  <= gs.alienHitPulse;
                f_dead   <= gs.playerHitByAlienPulse | gs.aliensReachedBorder;
                f_shot   <= gs.playerHitByRocketPulse;
                f_rocket <= gs.rocketsCollisionPulse;
            end else begin
                f_alien  <= f_alien  | gs.alienHitPulse;
                f_dead   <= f_dead   | gs.playerHitByAlienPulse | gs.aliensReachedBorder;
                f_shot   <= f_shot   | gs.playerHitByRocketPulse;
                f_rocket <= f_rocket | gs.rocketsCollisionPulse;
            end
        end
    end

    // Next-state and next-value logic for one frame evaluation
    always_comb begin
        state_d  = state_q;
        lives_d  = lives_q;
        score_d  = score_q;
        level_d  = level_q;
        aliens_d = aliens_q;
        cnt_d    = cnt_q;
        rc_d     = 1'b0;
        lu_d     = 1'b0;

        score_sum  = EXT_W'(score_q) + EXT_W'(f_rocket)
                   + (f_alien ? EXT_W'(ALIEN_POINTS) * EXT_W'(level_q) : '0);
        score_new  = (score_sum > EXT_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
        aliens_new = (f_alien && aliens_q != 6'd0) ? aliens_q - 6'd1 : aliens_q;
`ifdef GAME_BONUS_LIFE_EN
        bonus   = (32'(score_q) / 1000) != (32'(score_new) / 1000);
        lives_b = (bonus && lives_q != 3'd7) ? lives_q + 3'd1 : lives_q;
`else
        lives_b = lives_q;
`endif

        case (state_q)
            IDLE, GAME_OVER: begin
                if (start_edge) begin
                    state_d  = PLAY;
                    lives_d  = 3'(START_LIVES);
                    score_d  = '0;
                    level_d  = 3'd1;
                    aliens_d = 6'(NUM_ALIENS);
                    rc_d     = 1'b1;
                    lu_d     = 1'b1;
                end
            end
            PLAY: begin
                if (gs.startOfFrame) begin
                    score_d  = score_new;
                    aliens_d = aliens_new;
                    lives_d  = lives_b;
                    if (f_dead) begin
                        lives_d = '0;
                        state_d = GAME_OVER;
                    end else if (f_shot) begin
                        if (lives_b <= 3'd1) begin
                            lives_d = '0;
                            state_d = GAME_OVER;
                        end else begin
                            lives_d = lives_b - 3'd1;
                            state_d = PLAYER_HIT;
                            cnt_d   = CNT_W'(HIT_FREEZE_FRAMES);
                        end
                    end else if (aliens_new == 6'd0) begin
                        state_d = LEVEL_CLEAR;
                        cnt_d   = CNT_W'(CLEAR_FRAMES);
                    end
                end
            end
            PLAYER_HIT: begin
                if (gs.startOfFrame) begin
                    cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
                    if (expire) begin
                        rc_d = 1'b1;
                        if (aliens_q == 6'd0) begin
                            state_d = LEVEL_CLEAR;
                            cnt_d   = CNT_W'(CLEAR_FRAMES);
                        end else begin
                            state_d = PLAY;
                        end
                    end
                end
            end
            LEVEL_CLEAR: begin
                if (gs.startOfFrame) begin
                    cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
                    if (expire) begin
                        level_d  = (level_q >= 3'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : level_q + 3'd1;
                        aliens_d = 6'(NUM_ALIENS);
                        rc_d     = 1'b1;
                        lu_d     = 1'b1;
                        state_d  = PLAY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status flags decoded from the upcoming state so they register with it
    always_comb begin
        active_d = (state_d == PLAY) || (state_d == PLAYER_HIT) || (state_d == LEVEL_CLEAR);
        freeze_d = (state_d != PLAY);
        over_d   = (state_d == GAME_OVER);
    end

    assign gs.state         = state_q;
    assign gs.lives         = lives_q;
    assign gs.score         = score_q;
    assign gs.level         = level_q;
    assign gs.aliens_left   = aliens_q;
    assign gs.rockets_clear = rc_q;
    assign gs.level_up      = lu_q;
    assign gs.game_active   = active_q;
    assign gs.freeze        = freeze_q;
    assign gs.game_over     = over_q;
endmodule

// File: doc/game_state_sequencer.md
Name: game_state_sequencer

Overview:
- Top-level game flow FSM for the Space Invaders VGA design.
- Consumes the single-cycle collision pulses from the collision detector and the aliens-reached-border flag.
- Integrates them once per video frame. Sequences start / play / player-hit / level-clear / game-over.
- Owns lives, score, level and alien count. Drives freeze and rocket-clear controls back to the object movers.

Parameters:
START_LIVES, 3, lives loaded at game start (1..7)
NUM_ALIENS, 24, aliens per wave (1..63)
ALIEN_POINTS, 10, points per alien kill, multiplied by current level
HIT_FREEZE_FRAMES, 60, frames frozen after player loses a life
CLEAR_FRAMES, 90, frames frozen between waves
MAX_LEVEL, 7, level saturation value
SCORE_W, 14, score width; score saturates at 2^SCORE_W-1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
startOfFrame  in  1  one-cycle pulse at start of each frame
startKey  in  1  start button, already debounced; level signal
alienHitPulse  in  1  player rocket hit alien
playerHitByAlienPulse  in  1  alien body touched player
playerHitByRocketPulse  in  1  alien rocket hit player
rocketsCollisionPulse  in  1  player rocket hit alien rocket
aliensReachedBorder  in  1  aliens at bottom border
game_active  out  1  high in PLAY, PLAYER_HIT, LEVEL_CLEAR
freeze  out  1  high in PLAYER_HIT, LEVEL_CLEAR, GAME_OVER, IDLE
rockets_clear  out  1  one-cycle pulse: movers delete all rockets
level_up  out  1  one-cycle pulse: movers reload alien formation
lives  out  3  remaining lives
score  out  SCORE_W  current score
level  out  3  current level, 1..MAX_LEVEL
aliens_left  out  6  aliens remaining in wave
game_over  out  1  high in GAME_OVER
state  out  3  IDLE=0, PLAY=1, PLAYER_HIT=2, LEVEL_CLEAR=3, GAME_OVER=4

Behaviour:
Reset values:
- state IDLE.
- lives 0, score 0, level 1, aliens_left 0.
- All pulses and flags 0. freeze 1, game_active 0, game_over 0.

Reset mid-operation: reset has priority over every event. All registers take reset values on the next edge.

startKey:
- Registered internally. The start event is a 0->1 edge.
- A key held high across reset does not start a game.

Frame accumulation:
- Four sticky flags: alien_hit, player_dead, player_shot, rocket_hit.
- player_dead is set by either playerHitByAlienPulse or aliensReachedBorder.
- Flags set on any cycle the corresponding input is high, so several pulses in one frame count once.
- On a startOfFrame cycle, flags are evaluated, then cleared.
- An input high on that same cycle is captured into the new frame, not the evaluated one.
- Outside PLAY, flags are held cleared.

IDLE:
- On start edge -> PLAY.
- Load lives=START_LIVES, score=0, level=1, aliens_left=NUM_ALIENS.
- Pulse rockets_clear and level_up.

PLAY, at frame evaluation, applied in this order:
1. rocket_hit: score += 1.
2. alien_hit: score += ALIEN_POINTS*level; aliens_left -= 1 (no decrement below 0).
3. player_dead: lives=0 -> GAME_OVER.
4. Else player_shot: lives -= 1.
   - Result 0 -> GAME_OVER.
   - Otherwise -> PLAYER_HIT; load frame counter with HIT_FREEZE_FRAMES.
5. Else aliens_left now 0 -> LEVEL_CLEAR; load counter with CLEAR_FRAMES.

Score arithmetic uses a width-extended sum, then saturates.

PLAYER_HIT:
- Counter decrements on each startOfFrame.
- At 0, pulse rockets_clear.
- Then go to LEVEL_CLEAR (counter=CLEAR_FRAMES) if aliens_left==0, else to PLAY.

LEVEL_CLEAR:
- Counter decrements on each startOfFrame.
- At 0: level = min(level+1, MAX_LEVEL); aliens_left=NUM_ALIENS.
- Pulse level_up and rockets_clear; go to PLAY.

GAME_OVER:
- Score and level held.
- On start edge -> PLAY with the full IDLE load.

Output timing:
- All outputs are registered.
- Transitions take effect on the edge of the evaluating startOfFrame cycle; outputs are visible the following cycle.

Optional Feature:
- Macro: GAME_BONUS_LIFE_EN.
- Defined: when a score update crosses a multiple of 1000 (old/1000 != new/1000), lives += 1, saturating at 7.
  - The bonus is applied before the player_shot decrement in the same frame.
  - At most one bonus per frame.
- Undefined: lives only ever decrement or reload; no bonus logic is synthesised.

Test Plan:
- Reset, then startKey 0->1 -> state=1 and lives=3, score=0, level=1, aliens_left=24; rockets_clear and level_up each high exactly one cycle.
- In PLAY, 5 alienHitPulse in one frame -> next frame: score=10, aliens_left=23. alienHitPulse coincident with startOfFrame -> credited one frame later.
- playerHitByRocketPulse with lives=3 -> lives=2, state=2, freeze=1 for 60 frames, then rockets_clear pulse, state=1. Repeat with lives=1 -> lives=0, state=4, game_over=1.
- Kill 24 aliens at level 1 -> state=3, score=240; after 90 frames level=2, aliens_left=24, level_up pulse. Next kill adds 20.
- Same frame: last alien killed and player shot with lives=2 -> score credited, lives=1, PLAYER_HIT, then LEVEL_CLEAR, then PLAY at level 2. aliensReachedBorder in PLAY -> lives=0, GAME_OVER.
- With GAME_BONUS_LIFE_EN, score 990 + kill worth 10 -> score=1000, lives+1. Without the macro, lives unchanged. Separately, assert reset mid-LEVEL_CLEAR -> state=0, lives=0, freeze=1 next cycle.
